// File: rtl/mem_scrb_pkg.sv
// Shared types and constants for the DDR scrubber/verifier.
package mem_scrb_pkg;

  // dbg_state exposes the low 3 bits; DONE aliases IDLE there (scrb_done disambiguates).
  typedef enum logic [3:0] {
    IDLE     = 4'h0,
    START    = 4'h1,
    WR_AW    = 4'h2,
    WR_W     = 4'h3,
    WR_B     = 4'h4,
    RD_START = 4'h5,
    RD_AR    = 4'h6,
    RD_R     = 4'h7,
    DONE     = 4'h8
  } fsm_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/mem_scrb_verify_if.sv
// AXI-4 write/read channels between the scrubber (master) and the DDR controller (slave).
interface mem_scrb_verify_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 10
);

  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rlast;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arvalid,
    input  arready,
    input  rdata, rresp, rvalid, rlast,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arvalid,
    output arready,
    output rdata, rresp, rvalid, rlast,
    input  rready
  );

endinterface

// File: rtl/mem_scrb_patgen.sv
// Fill pattern for one beat: constant, or beat byte address XOR constant, replicated per 64-bit lane.
module mem_scrb_patgen #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512
) (
  input  logic [ADDR_WIDTH-1:0] beat_addr,
  input  logic [63:0]           cfg_pattern,
  input  logic                  cfg_pat_mode,
  output logic [DATA_WIDTH-1:0] pattern
);

  localparam int unsigned LANES = DATA_WIDTH / 64;

  logic [63:0] lane;

  // Build one lane and replicate it across the data bus.
  always_comb begin
    lane    = cfg_pat_mode ? (64'(beat_addr) ^ cfg_pattern) : cfg_pattern;
    pattern = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pattern[i*64 +: 64] = lane;
    end
  end

endmodule

// File: rtl/mem_scrb_verify.sv
// DDR scrubber/initialiser: fills an address range over AXI-4, optionally reads it back and counts mismatches.
module mem_scrb_verify
  import mem_scrb_pkg::*;
#(
  parameter int ADDR_WIDTH       = 64,
  parameter int DATA_WIDTH       = 512,
  parameter int ID_WIDTH         = 10,
  parameter int BURST_LEN_MINUS1 = 15,
  parameter int ERR_CNT_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     scrb_enable,
  input  logic [ADDR_WIDTH-1:0]    cfg_start_addr,
  input  logic [ADDR_WIDTH-1:0]    cfg_end_addr,
  input  logic [63:0]              cfg_pattern,
  input  logic                     cfg_pat_mode,
  input  logic                     cfg_verify,
  mem_scrb_verify_if.master        axi,
  output logic                     scrb_busy,
  output logic                     scrb_done,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic [2:0]               dbg_state
);

  localparam int unsigned           BEAT_BYTES  = DATA_WIDTH / 8;
  localparam int unsigned           BURST_BYTES = (BURST_LEN_MINUS1 + 1) * BEAT_BYTES;
  localparam logic [7:0]            LAST_BEAT   = 8'(BURST_LEN_MINUS1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_INC    = ADDR_WIDTH'(BEAT_BYTES);
  localparam logic [ADDR_WIDTH:0]   BURST_INC   = (ADDR_WIDTH + 1)'(BURST_BYTES);

  fsm_state_t            state_q, state_d;
  logic                  en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [7:0]            beat_cnt_q;
  logic [ADDR_WIDTH:0]   next_burst;
  logic                  at_end;
  logic                  last_beat;
  logic                  err_evt;
  logic [DATA_WIDTH-1:0] pattern;

  assign beat_addr = addr_q + ADDR_WIDTH'(beat_cnt_q) * BEAT_INC;

  // Final burst when the next one would start past cfg_end_addr. Equals addr >= end for an
  // aligned end; an unaligned end still covers its containing burst. One bit wider: no wrap.
  assign next_burst = {1'b0, addr_q} + BURST_INC;
  assign at_end     = next_burst > {1'b0, cfg_end_addr};
  assign last_beat  = beat_cnt_q == LAST_BEAT;

  mem_scrb_patgen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_patgen (
    .beat_addr    (beat_addr),
    .cfg_pattern  (cfg_pattern),
    .cfg_pat_mode (cfg_pat_mode),
    .pattern      (pattern)
  );

  assign err_evt = ((state_q == WR_B) && axi.bvalid && (axi.bresp != AXI_RESP_OKAY)) ||
                   ((state_q == RD_R) && axi.rvalid &&
                    ((axi.rresp != AXI_RESP_OKAY) || (axi.rdata != pattern)));

  assign axi.awid   = {ID_WIDTH{1'b0}};
  assign axi.arid   = {ID_WIDTH{1'b0}};
  assign axi.awlen  = LAST_BEAT;
  assign axi.arlen  = LAST_BEAT;
  assign axi.awaddr = addr_q;
  assign axi.araddr = addr_q;
  assign axi.wstrb  = '1;
  assign axi.bready = 1'b1;
  assign axi.rready = 1'b1;

  // Single synchronising register on the enable level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_q <= 1'b0;
    else        en_q <= scrb_enable;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; an abort is only honoured once the outstanding burst has fully completed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (en_q) state_d = START;
      START:    state_d = en_q ? WR_AW : IDLE;
      WR_AW:    if (axi.awready) state_d = WR_W;
      WR_W:     if (axi.wready && last_beat) state_d = WR_B;
      WR_B: begin
        if (axi.bvalid) begin
          if (!en_q)       state_d = IDLE;
          else if (at_end) state_d = cfg_verify ? RD_START : DONE;
          else             state_d = WR_AW;
        end
      end
      RD_START: state_d = en_q ? RD_AR : IDLE;
      RD_AR:    if (axi.arready) state_d = RD_R;
      RD_R: begin
        if (axi.rvalid && axi.rlast) begin
          if (!en_q)       state_d = IDLE;
          else if (at_end) state_d = DONE;
          else             state_d = RD_AR;
        end
      end
      DONE:     if (!en_q) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    axi.awvalid = state_q == WR_AW;
    axi.wvalid  = state_q == WR_W;
    axi.wlast   = (state_q == WR_W) && last_beat;
    axi.wdata   = (state_q == WR_W) ? pattern : '0;
    axi.arvalid = state_q == RD_AR;
    scrb_busy   = (state_q != IDLE) && (state_q != DONE);
    dbg_state   = state_q[2:0];
  end

  // Burst address and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        START, RD_START: begin
          addr_q     <= cfg_start_addr;
          beat_cnt_q <= '0;
        end
        WR_W: begin
          if (axi.wready) beat_cnt_q <= last_beat ? 8'd0 : beat_cnt_q + 8'd1;
        end
        WR_B: begin
          if (axi.bvalid && !at_end) addr_q <= next_burst[ADDR_WIDTH-1:0];
        end
        RD_R: begin
          if (axi.rvalid) begin
            if (axi.rlast) begin
              beat_cnt_q <= '0;
              if (!at_end) addr_q <= next_burst[ADDR_WIDTH-1:0];
            end else begin
              beat_cnt_q <= beat_cnt_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating error count and address of the first failing beat of the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (state_q == START) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (err_evt) begin
      if (err_cnt == '0) first_err_addr <= beat_addr;
      if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  // Completion flag, held while DONE and the enable stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scrb_done <= 1'b0;
    else        scrb_done <= (state_q == DONE) && en_q;
  end

endmodule
